rx_control_unit: RTL
====================

Name: rx_control_unit

Overview:
- Receive-path controller for the serial receiver; sits directly upstream of the bit/packet timer.
- Detects the start-bit falling edge on the raw serial line and drives the timer's enable_timer.
- Consumes the timer's packet_done, then checks the stop bit and issues load_buffer to the receive buffer.
- Tracks data_ready, framing_error and overrun_error status toward the host side.

Parameters:
SYNC_STAGES, 2, number of synchronizer flops on serial_in (legal range 2..4)
FILTER_CYCLES, 3, consecutive low samples required to confirm a start bit (used only with the optional feature)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
serial_in  input  1  raw asynchronous serial line, idle high
packet_done  input  1  one-cycle pulse from timer: start+data+stop bit time elapsed
stop_bit  input  1  stop bit value captured by the shift register
data_read  input  1  host has consumed the buffered byte (single-cycle pulse)
enable_timer  output  1  enables the bit/packet timer counters
sbc_clear  output  1  one-cycle clear to the stop-bit checker / shift path
sbc_enable  output  1  one-cycle strobe: stop bit is valid for checking
load_buffer  output  1  one-cycle strobe: copy shift-register data into the RX buffer
data_ready  output  1  a valid byte is held in the buffer
framing_error  output  1  last packet had stop_bit==0
overrun_error  output  1  new byte loaded while data_ready was still set
busy  output  1  high in every state except IDLE

Behaviour:
- Clock clk; reset rst is synchronous and active-high. While rst is sampled high: FSM goes to IDLE; every synchronizer flop loads 1; data_ready, framing_error and overrun_error load 0; all strobes are 0.
- Reset mid-packet aborts the packet. No load_buffer pulse is produced for it.
- Synchronizer: serial_in passes through SYNC_STAGES flops. The detector keeps a previous-sample flop, which also resets to 1.
- start_edge is combinational: previous sample == 1 and current synchronized sample == 0.
- FSM states and transitions, with outputs registered per state:
  - IDLE: busy=0. Goes to START on start_edge.
  - START: exactly 1 cycle. sbc_clear=1. framing_error is cleared here. Goes to RECEIVE.
  - RECEIVE: enable_timer=1. Stays until packet_done==1, then goes to STOP_WAIT. enable_timer is still 1 in the cycle packet_done is sampled.
  - STOP_WAIT: 1 cycle. enable_timer=0, sbc_enable=1. Goes to STOP_CHECK.
  - STOP_CHECK: 1 cycle. Goes to LOAD if stop_bit==1, otherwise to FRAME_ERR.
  - LOAD: 1 cycle. load_buffer=1. Goes to IDLE.
  - FRAME_ERR: 1 cycle. framing_error is set to 1 next edge and held until the next START. No load occurs. Goes to IDLE.
- Latency: a serial_in fall reaches START SYNC_STAGES+1 cycles later. packet_done to load_buffer is 3 cycles.
- start_edge outside IDLE is ignored. A new packet is only accepted after the FSM has returned to IDLE.
- data_ready status:
  - Set on the edge after LOAD.
  - Cleared on data_read when no LOAD occurs that cycle.
  - LOAD together with data_read: data_ready stays 1 and overrun_error is not set.
- overrun_error status:
  - Set when LOAD occurs with data_ready==1 and data_read==0. The buffer is overwritten.
  - Sticky; cleared on data_read.
- data_read while data_ready==0 has no effect.
- packet_done outside RECEIVE is ignored.

Optional Feature:
- Macro: START_GLITCH_FILTER_EN.
- When defined:
  - IDLE goes to an extra state START_FILTER on start_edge.
  - START_FILTER counts consecutive low synchronized samples, including the edge sample.
  - Reaching FILTER_CYCLES goes to START.
  - Any high sample returns to IDLE with no outputs asserted.
  - Edge-to-START latency becomes SYNC_STAGES+FILTER_CYCLES.
- When undefined: START_FILTER and its counter do not exist, and IDLE goes directly to START.

Test Plan:
- Reset: hold rst=1 for 2 cycles with serial_in=0 -> all outputs 0 and FSM in IDLE; release with serial_in=1 -> no spurious start.
- Good packet: drop serial_in at cycle 10, pulse packet_done at cycle 100, stop_bit=1 -> sbc_clear at cycle 13, enable_timer high cycles 14-100, sbc_enable at 101, load_buffer at 103, data_ready=1 from 104.
- Framing error: same stimulus with stop_bit=0 -> no load_buffer, framing_error=1 from cycle 104; it clears at the next packet's START.
- Overrun: two good packets with no data_read -> overrun_error=1 after the 2nd LOAD; then data_read=1 for 1 cycle -> data_ready=0 and overrun_error=0.
- Simultaneous events: data_read in the same cycle as LOAD -> data_ready stays 1, overrun_error stays 0. serial_in falling during RECEIVE -> no state change.
- Reset mid-packet: assert rst at cycle 50 of RECEIVE -> enable_timer=0 next cycle, no load_buffer afterwards. With START_GLITCH_FILTER_EN and FILTER_CYCLES=3: a 2-cycle low glitch -> FSM back to IDLE, no sbc_clear.

Source files
------------

// File: rtl/rx_control_unit.sv
// Receive-path controller: start-bit detection, timer enable, stop-bit check, RX status flags.
// Optional macro START_GLITCH_FILTER_EN adds a low-sample filter between IDLE and START.
module rx_control_unit #(
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned FILTER_CYCLES = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic serial_in,
  input  logic packet_done,
  input  logic stop_bit,
  input  logic data_read,
  output logic enable_timer,
  output logic sbc_clear,
  output logic sbc_enable,
  output logic load_buffer,
  output logic data_ready,
  output logic framing_error,
  output logic overrun_error,
  output logic busy
);

  if (SYNC_STAGES < 2 || SYNC_STAGES > 4 || FILTER_CYCLES < 1) begin : g_bad_cfg
    $error("rx_control_unit: SYNC_STAGES must be 2..4 and FILTER_CYCLES >= 1");
  end

  typedef enum logic [2:0] {
    IDLE,
    START,
    RECEIVE,
    STOP_WAIT,
    STOP_CHECK,
    LOAD,
    FRAME_ERR
`ifdef START_GLITCH_FILTER_EN
    , START_FILTER
`endif
  } state_t;

  state_t state_q, state_d;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   sample;
  logic                   start_edge;

  // Synchronizer plus previous-sample flop; both idle high out of reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '1;
      prev_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], serial_in};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign sample     = sync_q[SYNC_STAGES-1];
  assign start_edge = prev_q & ~sample;

`ifdef START_GLITCH_FILTER_EN
  localparam int unsigned FCW = $clog2(FILTER_CYCLES + 1);
  logic [FCW-1:0] filt_q, filt_d;

  always_ff @(posedge clk) begin
    if (rst) filt_q <= '0;
    else     filt_q <= filt_d;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
`ifdef START_GLITCH_FILTER_EN
    filt_d  = filt_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (start_edge) begin
`ifdef START_GLITCH_FILTER_EN
          state_d = START_FILTER;
          filt_d  = FCW'(1);
`else
          state_d = START;
`endif
        end
      end
`ifdef START_GLITCH_FILTER_EN
      // The edge sample already counts as the first low sample.
      START_FILTER: begin
        if (sample)                                    state_d = IDLE;
        else if (filt_q >= FCW'(FILTER_CYCLES - 1))    state_d = START;
        else                                           filt_d  = filt_q + FCW'(1);
      end
`endif
      START:      state_d = RECEIVE;
      RECEIVE:    if (packet_done) state_d = STOP_WAIT;
      STOP_WAIT:  state_d = STOP_CHECK;
      STOP_CHECK: state_d = stop_bit ? LOAD : FRAME_ERR;
      LOAD:       state_d = IDLE;
      FRAME_ERR:  state_d = IDLE;
      default:    state_d = IDLE;
    endcase
  end

  // Strobes decoded from the next state so they align with the state they belong to.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy          <= 1'b0;
      enable_timer  <= 1'b0;
      sbc_clear     <= 1'b0;
      sbc_enable    <= 1'b0;
      load_buffer   <= 1'b0;
      framing_error <= 1'b0;
      data_ready    <= 1'b0;
      overrun_error <= 1'b0;
    end else begin
      busy         <= (state_d != IDLE);
      enable_timer <= (state_d == RECEIVE);
      sbc_clear    <= (state_d == START);
      sbc_enable   <= (state_d == STOP_WAIT);
      load_buffer  <= (state_d == LOAD);

      if (state_d == START)          framing_error <= 1'b0;
      else if (state_q == FRAME_ERR) framing_error <= 1'b1;

      if (state_q == LOAD) begin
        data_ready <= 1'b1;
        if (data_ready && !data_read) overrun_error <= 1'b1;
        else if (data_read)           overrun_error <= 1'b0;
      end else if (data_read) begin
        data_ready    <= 1'b0;
        overrun_error <= 1'b0;
      end
    end
  end

endmodule
